// File: rtl/mips_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_controller_pkg
// Purpose  : Shared codes for the 8-bit multicycle MIPS control path:
//            FSM state encodings, opcode/funct values, ALU op classes and
//            ALU control codes.
// Revision : 1.0 - initial release
// ============================================================================
package mips_controller_pkg;

  // FSM states; FETCH1 must stay 0 so the reset state is all-zero
  localparam logic [3:0] S_FETCH1  = 4'd0;
  localparam logic [3:0] S_FETCH2  = 4'd1;
  localparam logic [3:0] S_FETCH3  = 4'd2;
  localparam logic [3:0] S_FETCH4  = 4'd3;
  localparam logic [3:0] S_DECODE  = 4'd4;
  localparam logic [3:0] S_MEMADR  = 4'd5;
  localparam logic [3:0] S_LBRD    = 4'd6;
  localparam logic [3:0] S_LBWR    = 4'd7;
  localparam logic [3:0] S_SBWR    = 4'd8;
  localparam logic [3:0] S_RTYPEEX = 4'd9;
  localparam logic [3:0] S_RTYPEWR = 4'd10;
  localparam logic [3:0] S_BEQEX   = 4'd11;
  localparam logic [3:0] S_JEX     = 4'd12;
  localparam logic [3:0] S_ADDIEX  = 4'd13;
  localparam logic [3:0] S_ADDIWR  = 4'd14;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU op class handed from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU control codes seen by the datapath
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage
`default_nettype wire

// File: rtl/mips_controller_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mips_controller_alu_decoder
// Purpose  : Maps the FSM's ALU op class and the R-type funct field onto the
//            3-bit ALU control code. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module mips_controller_alu_decoder
  import mips_controller_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  logic [1:0]         aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [2:0]         alucontrol
);

  // Select ALU function; unknown funct codes and the spare aluop fall back to add
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_controller.sv
`default_nettype none
// ============================================================================
// Module   : mips_controller
// Purpose  : Multicycle Moore control FSM for the 8-bit MIPS datapath.
//            Fetches a 32-bit instruction one byte per cycle, decodes it and
//            sequences execute / memory / writeback states.
// Revision : 1.0 - initial release
// ============================================================================
module mips_controller
  import mips_controller_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               reset,       // asynchronous, active low
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  output logic               memread,
  output logic               memwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               iord,
  output logic [3:0]         irwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               pcen,
  output logic [1:0]         pcsource,
  output logic [2:0]         alucontrol
);

  logic [3:0] state_q;
  logic [3:0] state_d;

  // Raw state decodes; the write-type strobes are gated by reset below
  logic       w_memread;
  logic       w_memwrite;
  logic [3:0] w_irwrite;
  logic       w_regwrite;
  logic       w_pcwrite;
  logic       w_branch;
  logic [1:0] w_aluop;

  // State register: the only flop in the controller
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH1;
    else        state_q <= state_d;
  end

  // Next-state logic; unsupported opcodes return to FETCH1 straight from DECODE
  always_comb begin
    state_d = S_FETCH1;
    case (state_q)
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_FETCH3;
      S_FETCH3: state_d = S_FETCH4;
      S_FETCH4: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH1;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LB) ? S_LBRD : S_SBWR;
      S_LBRD:    state_d = S_LBWR;
      S_RTYPEEX: state_d = S_RTYPEWR;
      S_ADDIEX:  state_d = S_ADDIWR;
      default:   state_d = S_FETCH1;
    endcase
  end

  // Output decode from state only; every control defaults to 0 (ALU add)
  always_comb begin
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 4'b0000;
    w_regwrite = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_aluop    = ALUOP_ADD;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    pcsource   = 2'b00;
    case (state_q)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        // PC + 1 through the ALU while the addressed byte lands in the IR
        w_memread = 1'b1;
        w_irwrite = 4'b0001 << state_q[1:0];
        alusrcb   = 2'b01;
        w_pcwrite = 1'b1;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_LBRD: begin
        w_memread = 1'b1;
        iord      = 1'b1;
      end
      S_LBWR: begin
        w_regwrite = 1'b1;
        memtoreg   = 1'b1;
      end
      S_SBWR: begin
        w_memwrite = 1'b1;
        iord       = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
      end
      S_RTYPEWR: begin
        w_regwrite = 1'b1;
        regdst     = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        w_branch = 1'b1;
        pcsource = 2'b01;
      end
      S_JEX: begin
        w_pcwrite = 1'b1;
        pcsource  = 2'b10;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWR: w_regwrite = 1'b1;
      default: ;
    endcase
  end

  // Reset low suppresses every strobe that could change architectural state
  assign memread  = w_memread  & reset;
  assign memwrite = w_memwrite & reset;
  assign irwrite  = w_irwrite  & {4{reset}};
  assign regwrite = w_regwrite & reset;
  assign pcen     = (w_pcwrite | (w_branch & zero)) & reset;

  mips_controller_alu_decoder #(
    .FUNCT_W (FUNCT_W)
  ) u_alu_decoder (
    .aluop      (w_aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule
`default_nettype wire

// File: tb/tb_mips_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_controller
// Purpose  : Directed self-checking bench for mips_controller. All control
//            outputs are packed into one vector and compared per cycle with
//            hand-derived expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] irwrite;
  logic [2:0] alucontrol;

  int checks   = 0;
  int failures = 0;

  mips_controller #(
    .OP_W    (6),
    .FUNCT_W (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memread    (memread),
    .memwrite   (memwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .iord       (iord),
    .irwrite    (irwrite),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .pcen       (pcen),
    .pcsource   (pcsource),
    .alucontrol (alucontrol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: memread memwrite alusrca alusrcb iord irwrite memtoreg regdst regwrite pcen pcsource alucontrol
  logic [18:0] obs;
  assign obs = {memread, memwrite, alusrca, alusrcb, iord, irwrite,
                memtoreg, regdst, regwrite, pcen, pcsource, alucontrol};

  function automatic logic [18:0] ev(input logic mr, input logic mw, input logic asa,
                                     input logic [1:0] asb, input logic io,
                                     input logic [3:0] irw, input logic mtr,
                                     input logic rd, input logic rw, input logic pe,
                                     input logic [1:0] pcs, input logic [2:0] alu);
    return {mr, mw, asa, asb, io, irw, mtr, rd, rw, pe, pcs, alu};
  endfunction

  task automatic chk(input string tag, input logic [18:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample well clear of the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expected vectors per state
  logic [18:0] v_rst, v_dec, v_memadr, v_lbrd, v_lbwr, v_sbwr, v_rwr;
  logic [18:0] v_beq_t, v_beq_nt, v_jex, v_addiex, v_addiwr;

  function automatic logic [18:0] v_fetch(input int n);
    logic [3:0] one;
    one = 4'b0001;
    return ev(1, 0, 0, 2'b01, 0, one << n, 0, 0, 0, 1, 2'b00, 3'b010);
  endfunction

  function automatic logic [18:0] v_rex(input logic [2:0] alu);
    return ev(0, 0, 1, 2'b00, 0, 4'b0000, 0, 0, 0, 0, 2'b00, alu);
  endfunction

  // Called while in FETCH1: checks FETCH1..FETCH4 and ends sampled in DECODE
  task automatic fetch_seq(input string tag);
    chk({tag, "_f1"}, v_fetch(0));
    for (int n = 1; n < 4; n++) begin
      tick();
      chk($sformatf("%s_f%0d", tag, n + 1), v_fetch(n));
    end
    tick();
    chk({tag, "_dec"}, v_dec);
  endtask

  logic [5:0] fn_tab  [3];
  logic [2:0] alu_tab [3];

  initial begin
    v_rst     = ev(0, 0, 0, 2'b01, 0, 4'b0000, 0, 0, 0, 0, 2'b00, 3'b010);
    v_dec     = ev(0, 0, 0, 2'b11, 0, 4'b0000, 0, 0, 0, 0, 2'b00, 3'b010);
    v_memadr  = ev(0, 0, 1, 2'b10, 0, 4'b0000, 0, 0, 0, 0, 2'b00, 3'b010);
    v_lbrd    = ev(1, 0, 0, 2'b00, 1, 4'b0000, 0, 0, 0, 0, 2'b00, 3'b010);
    v_lbwr    = ev(0, 0, 0, 2'b00, 0, 4'b0000, 1, 0, 1, 0, 2'b00, 3'b010);
    v_sbwr    = ev(0, 1, 0, 2'b00, 1, 4'b0000, 0, 0, 0, 0, 2'b00, 3'b010);
    v_rwr     = ev(0, 0, 0, 2'b00, 0, 4'b0000, 0, 1, 1, 0, 2'b00, 3'b010);
    v_beq_t   = ev(0, 0, 1, 2'b00, 0, 4'b0000, 0, 0, 0, 1, 2'b01, 3'b110);
    v_beq_nt  = ev(0, 0, 1, 2'b00, 0, 4'b0000, 0, 0, 0, 0, 2'b01, 3'b110);
    v_jex     = ev(0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 0, 1, 2'b10, 3'b010);
    v_addiex  = ev(0, 0, 1, 2'b10, 0, 4'b0000, 0, 0, 0, 0, 2'b00, 3'b010);
    v_addiwr  = ev(0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 1, 0, 2'b00, 3'b010);
    fn_tab[0] = 6'b100100; alu_tab[0] = 3'b000;   // and
    fn_tab[1] = 6'b100101; alu_tab[1] = 3'b001;   // or
    fn_tab[2] = 6'b101010; alu_tab[2] = 3'b111;   // slt

    // Reset held low for two cycles: strobes forced off
    reset = 1'b0; op = 6'b000000; funct = 6'b000000; zero = 1'b0;
    tick(); chk("rst_c1", v_rst);
    tick(); chk("rst_c2", v_rst);

    // add $1,$2,$3 : 7 cycles, back in FETCH1 on cycle 8
    funct = 6'b100000;
    reset = 1'b1; #1;
    fetch_seq("radd");
    tick(); chk("radd_ex", v_rex(3'b010));
    tick(); chk("radd_wr", v_rwr);
    tick(); chk("radd_next_f1", v_fetch(0));

    // sub via funct
    funct = 6'b100010;
    fetch_seq("rsub");
    tick(); chk("rsub_ex", v_rex(3'b110));
    tick(); chk("rsub_wr", v_rwr);
    tick();

    // and / or / slt through the funct map
    for (int i = 0; i < 3; i++) begin
      funct = fn_tab[i];
      fetch_seq($sformatf("rfn%0d", i));
      tick(); chk($sformatf("rfn%0d_ex", i), v_rex(alu_tab[i]));
      tick(); chk($sformatf("rfn%0d_wr", i), v_rwr);
      tick();
    end

    // beq taken
    op = 6'b000100; zero = 1'b1;
    fetch_seq("beqt");
    tick(); chk("beqt_ex", v_beq_t);
    tick(); chk("beqt_next_f1", v_fetch(0));

    // beq not taken
    zero = 1'b0;
    fetch_seq("beqn");
    tick(); chk("beqn_ex", v_beq_nt);
    tick(); chk("beqn_next_f1", v_fetch(0));

    // lb : 8 cycles
    op = 6'b100000;
    fetch_seq("lb");
    tick(); chk("lb_memadr", v_memadr);
    tick(); chk("lb_rd", v_lbrd);
    tick(); chk("lb_wr", v_lbwr);
    tick(); chk("lb_next_f1", v_fetch(0));

    // sb : 7 cycles
    op = 6'b101000;
    fetch_seq("sb");
    tick(); chk("sb_memadr", v_memadr);
    tick(); chk("sb_wr", v_sbwr);
    tick(); chk("sb_next_f1", v_fetch(0));

    // j : 6 cycles
    op = 6'b000010;
    fetch_seq("j");
    tick(); chk("j_ex", v_jex);
    tick(); chk("j_next_f1", v_fetch(0));

    // addi : 7 cycles
    op = 6'b001000;
    fetch_seq("addi");
    tick(); chk("addi_ex", v_addiex);
    tick(); chk("addi_wr", v_addiwr);
    tick(); chk("addi_next_f1", v_fetch(0));

    // unknown opcode: DECODE then straight back to FETCH1
    op = 6'b111111;
    fetch_seq("nop");
    tick(); chk("nop_next_f1", v_fetch(0));

    // unknown funct falls back to add
    op = 6'b000000; funct = 6'b000001;
    fetch_seq("rbad");
    tick(); chk("rbad_ex", v_rex(3'b010));
    tick(); chk("rbad_wr", v_rwr);
    tick(); chk("rbad_next_f1", v_fetch(0));

    // Reset pulled during LBRD aborts the load
    op = 6'b100000;
    fetch_seq("lbab");
    tick(); chk("lbab_memadr", v_memadr);
    tick(); chk("lbab_rd", v_lbrd);
    reset = 1'b0; #1;
    chk("lbab_rst_now", v_rst);
    tick(); chk("lbab_rst_held", v_rst);
    reset = 1'b1; #1;
    chk("lbab_rel_f1", v_fetch(0));
    tick(); chk("lbab_rel_f2", v_fetch(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
